// File: rtl/mac_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_ctrl_if
//  Brief    : Command, operand, MAC and result signals of the MAC sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_seq_ctrl_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 9,
    parameter int LEN_BW  = 4
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_BW-1:0]  cmd_len;
    logic [PSUM_BW-1:0] cmd_bias;
    logic               abort;

    logic               in_valid;
    logic               in_ready;
    logic [BW-1:0]      in_a;
    logic [BW-1:0]      in_b;

    logic [BW-1:0]      mac_a;
    logic [BW-1:0]      mac_b;
    logic [PSUM_BW-1:0] mac_c;
    logic [PSUM_BW-1:0] mac_out;

    logic               out_valid;
    logic               out_ready;
    logic [PSUM_BW-1:0] out_psum;
    logic               busy;
    logic [LEN_BW-1:0]  cnt;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_len, cmd_bias, abort,
        input  in_valid, in_a, in_b,
        input  mac_out, out_ready,
        output cmd_ready, in_ready,
        output mac_a, mac_b, mac_c,
        output out_valid, out_psum, busy, cnt
    );

    // Environment side: operand buffers, MAC and psum writer
    modport master (
        output cmd_valid, cmd_len, cmd_bias, abort,
        output in_valid, in_a, in_b,
        output mac_out, out_ready,
        input  cmd_ready, in_ready,
        input  mac_a, mac_b, mac_c,
        input  out_valid, out_psum, busy, cnt
    );
endinterface
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_ctrl
//  Brief    : Sequences one dot-product command through a shared external MAC.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 9,
    parameter int LEN_BW  = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mac_seq_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PSUM_BW-1:0] psum_q, psum_d;
    logic [PSUM_BW-1:0] out_psum_q, out_psum_d;
    logic [LEN_BW-1:0]  cnt_q, cnt_d;
    logic [LEN_BW-1:0]  len_q, len_d;
    logic               w_last_pair;

    // len_q is never zero while in ACC, so the decrement cannot underflow there
    assign w_last_pair = (cnt_q == (len_q - LEN_BW'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            psum_q     <= '0;
            out_psum_q <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            psum_q     <= psum_d;
            out_psum_q <= out_psum_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        psum_d  = psum_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.abort && bus.cmd_valid) begin
                    psum_d  = bus.cmd_bias;
                    len_d   = bus.cmd_len;
                    cnt_d   = '0;
                    state_d = (bus.cmd_len != '0) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    psum_d  = '0;
                    cnt_d   = '0;
                end else if (bus.in_valid) begin
                    psum_d = bus.mac_out;
                    cnt_d  = cnt_q + LEN_BW'(1);
                    if (w_last_pair) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    psum_d  = '0;
                    cnt_d   = '0;
                end else if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Result register is loaded on DONE entry and then frozen until the next result
        out_psum_d = (state_d == S_DONE) ? psum_d : out_psum_q;
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.cnt       = cnt_q;
    assign bus.out_psum  = out_psum_q;

    assign bus.mac_a = BW'(bus.in_a);
    assign bus.mac_b = BW'(bus.in_b);
    assign bus.mac_c = psum_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_seq_ctrl
//  Brief    : Scoreboard bench for mac_seq_ctrl with a behavioural MAC model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;
    localparam int BW      = 4;
    localparam int PSUM_BW = 9;
    localparam int LEN_BW  = 4;
    localparam int N_RESULTS = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.BW(BW), .PSUM_BW(PSUM_BW), .LEN_BW(LEN_BW)) bus ();

    mac_seq_ctrl #(.BW(BW), .PSUM_BW(PSUM_BW), .LEN_BW(LEN_BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared MAC: unsigned a times signed b plus c, wrapping to PSUM_BW bits
    logic signed [15:0] w_ma, w_mb, w_mc, w_mac_full;
    assign w_ma       = 16'($signed({1'b0, bus.mac_a}));
    assign w_mb       = 16'($signed(bus.mac_b));
    assign w_mc       = 16'($signed(bus.mac_c));
    assign w_mac_full = w_ma * w_mb + w_mc;
    assign bus.mac_out = w_mac_full[PSUM_BW-1:0];

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic [PSUM_BW-1:0] exp_q[$];
    int pa[16];
    int pb[16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result handshakes and hold-stability are judged mid-cycle, when inputs are settled
    always @(negedge clk) begin
        if (!reset && !bus.abort && bus.out_valid) begin
            if (bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check_eq("sb_unexpected_result", 32'd1, 32'd0);
                else check_eq("sb_psum", 32'(bus.out_psum), 32'(exp_q.pop_front()));
            end else if (exp_q.size() != 0) begin
                check_eq("hold_psum", 32'(bus.out_psum), 32'(exp_q[0]));
            end
        end
    end

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_bias  = '0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_busy",      32'(bus.busy),      32'd0);
        check_eq("rst_out_psum",  32'(bus.out_psum),  32'd0);
        check_eq("rst_cnt",       32'(bus.cnt),       32'd0);
        check_eq("rst_psum",      32'(bus.mac_c),     32'd0);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_pairs(input int a0, input int b0, input int a1, input int b1,
                             input int a2, input int b2, input int a3, input int b3);
        pa[0] = a0; pb[0] = b0;
        pa[1] = a1; pb[1] = b1;
        pa[2] = a2; pb[2] = b2;
        pa[3] = a3; pb[3] = b3;
    endtask

    task automatic send_cmd(input int len, input int bias);
        check_eq("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_BW'(len);
        bus.cmd_bias  = PSUM_BW'(bias);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // bubbles: bit i set means no operand offered in ACC cycle i
    task automatic run_dot(input int len, input int bias, input int bubbles, input int hold);
        int acc;
        int k;
        int i;
        logic [PSUM_BW-1:0] e;
        acc = bias;
        for (int j = 0; j < len; j++) acc += pa[j] * pb[j];
        e = PSUM_BW'(acc);
        exp_q.push_back(e);
        send_cmd(len, bias);
        k = 0;
        i = 0;
        while (k < len && i < 40) begin
            bus.in_valid = !bubbles[i];
            bus.in_a = bus.in_valid ? BW'(pa[k]) : BW'($urandom);
            bus.in_b = bus.in_valid ? BW'(pb[k]) : BW'($urandom);
            check_eq("acc_in_ready",  32'(bus.in_ready),  32'd1);
            check_eq("acc_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
            if (bus.in_valid) k++;
            i++;
            check_eq("acc_cnt", 32'(bus.cnt), 32'(k));
        end
        bus.in_valid = 1'b0;
        check_eq("done_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("done_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("done_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("done_busy",      32'(bus.busy),      32'd1);
        check_eq("done_out_psum",  32'(bus.out_psum),  32'(e));
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_len   = LEN_BW'(7);
            step();
            check_eq("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_eq("hold_cnt",       32'(bus.cnt),       32'(len));
        end
        bus.cmd_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("post_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("post_busy",      32'(bus.busy),      32'd0);
        check_eq("post_cnt",       32'(bus.cnt),       32'(len));
        check_eq("post_out_psum",  32'(bus.out_psum),  32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        do_reset();

        // Basic: 6 - 5 - 120 = -119
        set_pairs(3, 2, 5, -1, 15, -8, 0, 0);
        run_dot(3, 0, 0, 0);

        // Wrap: 4 * 105 = 420, no saturation
        set_pairs(15, 7, 15, 7, 15, 7, 15, 7);
        run_dot(4, 0, 0, 0);

        // Zero length: result is the bias
        run_dot(0, 5, 0, 0);

        // Bubbles (valid pattern 1,0,0,1) and 3 cycles of output backpressure
        set_pairs(7, -3, 2, 5, 0, 0, 0, 0);
        run_dot(2, 3, 32'b0110, 3);

        // Abort in ACC after two pairs, asserted together with an offered pair
        set_pairs(1, 1, 2, 2, 3, 3, 4, 4);
        send_cmd(5, 0);
        for (int j = 0; j < 2; j++) begin
            bus.in_valid = 1'b1;
            bus.in_a = BW'(pa[j]);
            bus.in_b = BW'(pb[j]);
            step();
        end
        bus.abort = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("abort_acc_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("abort_acc_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("abort_acc_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_acc_busy",      32'(bus.busy),      32'd0);
        check_eq("abort_acc_cnt",       32'(bus.cnt),       32'd0);
        check_eq("abort_acc_psum",      32'(bus.mac_c),     32'd0);

        // Abort in IDLE beats a simultaneous command
        bus.abort     = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_BW'(3);
        step();
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b0;
        check_eq("abort_idle_busy",      32'(bus.busy),      32'd1 - 32'd1);
        check_eq("abort_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        set_pairs(4, 3, 0, 0, 0, 0, 0, 0);
        run_dot(1, 0, 0, 0);

        // Abort in DONE beats out_ready: no result, psum cleared, out_psum held
        exp_q.push_back(PSUM_BW'(9));
        send_cmd(0, 9);
        check_eq("abort_done_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        bus.abort     = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.abort     = 1'b0;
        check_eq("abort_done_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_done_psum",      32'(bus.mac_c),     32'd0);
        check_eq("abort_done_cnt",       32'(bus.cnt),       32'd0);
        check_eq("abort_done_out_psum",  32'(bus.out_psum),  32'd9);
        exp_q.delete();

        // Reset mid-ACC, then a fresh command behaves as after power-up
        send_cmd(3, 0);
        bus.in_valid = 1'b1;
        bus.in_a = BW'(3);
        bus.in_b = BW'(2);
        step();
        do_reset();
        set_pairs(3, 2, 5, -1, 15, -8, 0, 0);
        run_dot(3, 0, 0, 0);

        // Reset while holding a result in DONE
        exp_q.push_back(PSUM_BW'(5));
        send_cmd(0, 5);
        check_eq("rst_done_pre_valid", 32'(bus.out_valid), 32'd1);
        do_reset();

        step();
        check_eq("sb_empty",  32'(exp_q.size()), 32'd0);
        check_eq("n_results", 32'(n_out),        32'(N_RESULTS));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for a single shared MAC datapath (unsigned activation × signed weight + partial sum).
- Accepts a dot-product command (length, initial bias), streams activation/weight pairs through the MAC one per cycle, and holds the running partial sum in its own register.
- Returns the finished partial sum on a valid/ready output.
- Sits between the input operand buffers and the output/psum SRAM writer.

Parameters:
- bw, 4, activation and weight width
- psum_bw, 9, partial-sum/accumulator width (two's complement)
- len_bw, 4, width of the command length field (max vector length 2^len_bw-1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_len  input  len_bw  number of (a,b) pairs in the dot product, unsigned
- cmd_bias  input  psum_bw  initial accumulator value, signed
- abort  input  1  synchronous cancel of the current command
- in_valid  input  1  operand pair present
- in_ready  output  1  controller consuming operands
- in_a  input  bw  activation, unsigned
- in_b  input  bw  weight, signed
- mac_a  output  bw  to MAC activation port
- mac_b  output  bw  to MAC weight port
- mac_c  output  psum_bw  to MAC accumulate port
- mac_out  input  psum_bw  MAC result, combinational from mac_a/b/c
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_psum  output  psum_bw  finished partial sum
- busy  output  1  high in ACC or DONE
- cnt  output  len_bw  pairs accepted for current command

Behaviour:
- States: IDLE, ACC, DONE.
- Reset (sync, any state):
  - state=IDLE, psum=0, cnt=0, len register=0.
  - Outputs: cmd_ready=1, in_ready=0, out_valid=0, busy=0, out_psum=0.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On cmd_valid: psum<=cmd_bias, len<=cmd_len, cnt<=0.
  - Next state is ACC if cmd_len≠0, else DONE (result = bias, out_valid next cycle).
- ACC:
  - in_ready=1, cmd_ready=0.
  - Each cycle with in_valid: psum<=mac_out and cnt<=cnt+1.
  - When the accepted pair is number len (cnt==len-1 at handshake), go to DONE.
  - in_valid low stalls with no state change; bubbles are allowed anywhere.
- DONE:
  - out_valid=1, out_psum=psum, held stable until out_ready.
  - On out_ready: go to IDLE; psum and cnt are retained until the next command.
  - No new command is accepted in DONE (cmd_ready=0); commands do not overlap.
- MAC drive (combinational):
  - mac_a=in_a, mac_b=in_b, mac_c=psum.
  - The MAC computes unsigned(a)×signed(b)+c.
  - Result truncated to psum_bw, wraps modulo 2^psum_bw; no saturation.
- Latency:
  - Pair k is accepted at cycle k after the command, with no bubbles.
  - out_valid rises the cycle after the last pair handshake, so a len-N command takes N+1 cycles to out_valid.
- abort:
  - From ACC or DONE: go to IDLE next cycle, no result emitted; out_valid and in_ready drop that edge. psum and cnt are cleared to 0.
  - In IDLE: abort has priority over cmd_valid (command not accepted).
- Simultaneous events:
  - Reset has priority over abort; abort has priority over all handshakes in the same cycle.
- out_psum:
  - Registered; reflects psum only while out_valid.
  - Held at its last value otherwise (0 after reset).

Test Plan:
- Basic: cmd len=3, bias=0; pairs (3,2),(5,-1),(15,-8) back-to-back -> out_valid 4 cycles after cmd accept, out_psum=-119 (0x189), cnt=3.
- Wrap: len=4, bias=0, four pairs (15,7) -> out_psum=420 mod 512 = 0x1A4 (-92 signed); no saturation.
- Zero length: cmd len=0, bias=5 -> in_ready never high, out_valid next cycle with out_psum=5.
- Backpressure/bubbles: len=2, in_valid pattern 1,0,0,1; out_ready held low 3 cycles -> cnt advances only on handshakes, out_valid/out_psum stable, cmd_ready=0 until out_ready, then IDLE.
- Abort: len=5, abort after 2 pairs -> IDLE next cycle, no out_valid, psum=0. A following len=1 (4,3) bias=0 command -> out_psum=12.
- Reset mid-ACC and in DONE: -> all outputs at reset values next cycle. A subsequent command behaves identically to a fresh-reset command.
